// File: rtl/rt_block_write_seq.sv
// rt_block_write_seq
//   Buffers one real-time block-write packet (NUM_CHAN per-channel command
//   quads plus a trailing trigger/control quad) and replays it as a
//   sequenced register-write burst on the bw_* port set. The top level
//   muxes the bw_* signals onto the register bus while bw_write_en=1.
//
//   Compile-time option: define RT_WRITE_TIMEOUT_EN to abandon a partial
//   packet (channel quads seen, no trigger) after TIMEOUT_CYCLES idle
//   cycles. Without it a partial packet waits indefinitely.
//
// Ports
//   sysclk, reset      clock, synchronous active-high reset
//   rt_wen/waddr/wdata real-time quad stream (one cycle per quad)
//   rt_overrun_clr     clears the sticky overrun flag
//   bw_write_en        this block owns the write bus
//   bw_reg_waddr/wdata {chan, offset} address and data of the write
//   bw_reg_wen         single-register write strobe
//   bw_blk_wstart/wen  start / end of block strobes
//   rt_busy            burst in progress
//   rt_overrun         sticky: a quad arrived during a burst and was dropped
//   rt_pkt_count       completed bursts (wrapping)

module rt_block_write_seq #(
    parameter int          NUM_CHAN       = 4,
    parameter logic [3:0]  DAC_OFFSET     = 4'h1,
    parameter logic [7:0]  CTRL_ADDR      = 8'h00,
    parameter int          TIMEOUT_CYCLES = 4096
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        rt_wen,
    input  logic [3:0]  rt_waddr,
    input  logic [31:0] rt_wdata,
    input  logic        rt_overrun_clr,
    output logic        bw_write_en,
    output logic [7:0]  bw_reg_waddr,
    output logic [31:0] bw_reg_wdata,
    output logic        bw_reg_wen,
    output logic        bw_blk_wen,
    output logic        bw_blk_wstart,
    output logic        rt_busy,
    output logic        rt_overrun,
    output logic [15:0] rt_pkt_count
);

    if (NUM_CHAN < 1 || NUM_CHAN > 14) begin : g_bad_num_chan
        $error("rt_block_write_seq: NUM_CHAN must be in 1..14");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("rt_block_write_seq: TIMEOUT_CYCLES must be >= 2");
    end

    localparam logic [3:0] NCH  = 4'(NUM_CHAN);
    localparam logic [3:0] LAST = 4'(NUM_CHAN - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_COLLECT, S_START, S_CH_SETUP,
        S_CH_WEN, S_CTRL_SETUP, S_CTRL_WEN, S_BLK_END
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          c_q, c_d;
    logic [31:0]         buf_q [NUM_CHAN];
    logic [NUM_CHAN-1:0] recv_q;
    logic [31:0]         ctrl_q;
    logic                ovr_q;
    logic [15:0]         cnt_q;

    logic        cap, accept, trig, drop, tmo_fire;
    logic [31:0] cur_buf;
    logic        cur_sel;

    // Quads are only accepted while no burst is running.
    assign cap    = (state_q == S_IDLE) || (state_q == S_COLLECT);
    assign accept = cap && rt_wen && (rt_waddr < NCH);
    assign trig   = cap && rt_wen && (rt_waddr == NCH);
    assign drop   = rt_wen && !cap;

    // Buffer entry and selection for the channel currently being replayed.
    always_comb begin
        cur_buf = '0;
        cur_sel = 1'b0;
        for (int i = 0; i < NUM_CHAN; i++) begin
            if (c_q == 4'(i)) begin
                cur_buf = buf_q[i];
                cur_sel = recv_q[i] && buf_q[i][31];
            end
        end
    end

`ifdef RT_WRITE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    logic [TW-1:0] tmo_q;

    // Counts idle cycles in COLLECT; any accepted quad restarts it.
    assign tmo_fire = (state_q == S_COLLECT) && !accept && !trig &&
                      (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge sysclk) begin
        if (reset)                                 tmo_q <= '0;
        else if (state_q != S_COLLECT || accept)   tmo_q <= '0;
        else if (!tmo_fire)                        tmo_q <= tmo_q + 1'b1;
    end
`else
    assign tmo_fire = 1'b0;
`endif

    // State register
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q <= S_IDLE;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        case (state_q)
            S_IDLE: begin
                if (trig)        state_d = S_START;
                else if (accept) state_d = S_COLLECT;
            end
            S_COLLECT: begin
                if (trig)          state_d = S_START;
                else if (tmo_fire) state_d = S_IDLE;
            end
            S_START: begin
                c_d     = '0;
                state_d = S_CH_SETUP;
            end
            S_CH_SETUP: begin
                if (cur_sel) begin
                    state_d = S_CH_WEN;
                end else begin
                    c_d     = c_q + 4'd1;
                    state_d = (c_q == LAST) ? S_CTRL_SETUP : S_CH_SETUP;
                end
            end
            S_CH_WEN: begin
                c_d     = c_q + 4'd1;
                state_d = (c_q == LAST) ? S_CTRL_SETUP : S_CH_SETUP;
            end
            S_CTRL_SETUP: state_d = S_CTRL_WEN;
            S_CTRL_WEN:   state_d = S_BLK_END;
            S_BLK_END:    state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase
    end

    // Output decode: the bus is driven purely from the state, so a reset
    // mid-burst releases it on the very next edge.
    always_comb begin
        bw_write_en   = 1'b0;
        bw_blk_wstart = 1'b0;
        bw_reg_wen    = 1'b0;
        bw_blk_wen    = 1'b0;
        bw_reg_waddr  = '0;
        bw_reg_wdata  = '0;
        case (state_q)
            S_START: begin
                bw_write_en   = 1'b1;
                bw_blk_wstart = 1'b1;
            end
            S_CH_SETUP, S_CH_WEN: begin
                bw_write_en  = 1'b1;
                bw_reg_waddr = {c_q + 4'd1, DAC_OFFSET};
                bw_reg_wdata = cur_buf;
                bw_reg_wen   = (state_q == S_CH_WEN);
            end
            S_CTRL_SETUP, S_CTRL_WEN: begin
                bw_write_en  = 1'b1;
                bw_reg_waddr = CTRL_ADDR;
                bw_reg_wdata = ctrl_q;
                bw_reg_wen   = (state_q == S_CTRL_WEN);
            end
            S_BLK_END: begin
                bw_write_en = 1'b1;
                bw_blk_wen  = 1'b1;
            end
            default: ;
        endcase
    end

    assign rt_busy      = !cap;
    assign rt_overrun   = ovr_q;
    assign rt_pkt_count = cnt_q;

    // Packet buffers, overrun flag and burst counter
    always_ff @(posedge sysclk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CHAN; i++) buf_q[i] <= '0;
            recv_q <= '0;
            ctrl_q <= '0;
            ovr_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            if (accept) begin
                for (int i = 0; i < NUM_CHAN; i++) begin
                    if (rt_waddr == 4'(i)) begin
                        buf_q[i]  <= rt_wdata;
                        recv_q[i] <= 1'b1;
                    end
                end
            end
            if (trig) ctrl_q <= rt_wdata;
            if (state_q == S_BLK_END || tmo_fire) recv_q <= '0;
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop)                ovr_q <= 1'b1;
            else if (rt_overrun_clr) ovr_q <= 1'b0;
            if (state_q == S_BLK_END) cnt_q <= cnt_q + 16'd1;
        end
    end

endmodule
